step_pulse_gen: RTL and testbench

//  Upstream stage for the 2-bit up/down step counter. Turns two raw pushbuttons (up, down)

---
 rtl/step_gen_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 69 ++++++
 rtl/step_pulse_gen.sv | 173 +++++++++++++++++
 tb/tb_step_pulse_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/step_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : step_gen_pkg
//  Purpose  : Shared types and constants for the step pulse generator and the
//             2-bit up/down step counter bench (FSM state encoding, direction
//             levels, small elaboration helper).
//  Revision : 1.0  initial release
// ============================================================================
package step_gen_pkg;

    // Pulse sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } step_state_e;

    // Direction level presented on up_down
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Larger of two integers, used to size shared timers
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : One pushbutton input path: 2-FF synchroniser, debounce counter
//             requiring DB_CYCLES consecutive differing samples before the
//             stable level follows, and a registered rising-edge detect.
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce
    import step_gen_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,      // asynchronous, active-low
    input  logic btn_i,      // raw asynchronous button
    output logic level_o,    // debounced level
    output logic rise_o      // one-clk pulse on debounced rising edge
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          prev_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count clocks of disagreement; accept the new level on the DB_CYCLES-th one
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser, debounce state and edge detect registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            prev_q   <= stable_q;
            rise_q   <= stable_q & ~prev_q;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;

endmodule
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : step_pulse_gen
//  Purpose  : Converts two raw pushbuttons into clean single step pulses
//             (step_clk) plus a direction level (up_down) for the 2-bit
//             up/down step counter. up_down is loaded one clk before the
//             step_clk rising edge and held while step_clk is high.
//  Options  : AUTO_REPEAT_EN - when defined, holding a single button repeats
//             steps every REPEAT_CYCLES after HOLD_CYCLES. When undefined the
//             hold logic and its two parameters are not present.
//  Revision : 1.0  initial release
// ============================================================================
module step_pulse_gen
    import step_gen_pkg::*;
#(
    parameter int DB_CYCLES     = 16,
    parameter int PULSE_W       = 4,
    parameter int GAP_W         = 4
`ifdef AUTO_REPEAT_EN
    ,
    parameter int HOLD_CYCLES   = 64,
    parameter int REPEAT_CYCLES = 32
`endif
) (
    input  logic clk,
    input  logic reset,      // asynchronous, active-low
    input  logic btn_up,
    input  logic btn_down,
    output logic step_clk,
    output logic up_down,
    output logic busy
);

    localparam int TW = $clog2(max_int(PULSE_W, GAP_W) + 1);

    logic up_lvl;
    logic up_rise;
    logic dn_lvl;
    logic dn_rise;
    logic up_req;
    logic dn_req;
    logic up_go;
    logic dn_go;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_up),
        .level_o (up_lvl),
        .rise_o  (up_rise)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_down),
        .level_o (dn_lvl),
        .rise_o  (dn_rise)
    );

`ifdef AUTO_REPEAT_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [HW-1:0] hold_q;
    logic [RW-1:0] rep_q;
    logic          rep_req_q;
    logic          single;

    // Only a lone pressed button may auto-repeat; both or none restarts the hold
    assign single = up_lvl ^ dn_lvl;

    // Hold timer saturates at HOLD_CYCLES, then the repeat timer paces requests
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q    <= '0;
            rep_q     <= '0;
            rep_req_q <= 1'b0;
        end else begin
            rep_req_q <= 1'b0;
            if (!single) begin
                hold_q <= '0;
                rep_q  <= '0;
            end else if (hold_q != HW'(HOLD_CYCLES)) begin
                hold_q <= hold_q + HW'(1);
                rep_q  <= '0;
            end else if (rep_q == RW'(REPEAT_CYCLES - 1)) begin
                rep_q     <= '0;
                rep_req_q <= 1'b1;
            end else begin
                rep_q <= rep_q + RW'(1);
            end
        end
    end

    assign up_req = up_rise | (rep_req_q & up_lvl);
    assign dn_req = dn_rise | (rep_req_q & dn_lvl);
`else
    assign up_req = up_rise;
    assign dn_req = dn_rise;
`endif

    // A request is honoured only if it is alone and the other button is released
    assign up_go = up_req & ~dn_req & ~dn_lvl;
    assign dn_go = dn_req & ~up_req & ~up_lvl;

    step_state_e   state_q;
    logic [TW-1:0] timer_q;
    logic          step_q;
    logic          dir_q;
    logic          busy_q;

    // Pulse sequencer: IDLE -> SETUP (direction settles) -> HIGH -> LOW -> IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            step_q  <= 1'b0;
            dir_q   <= DIR_UP;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (up_go) begin
                        dir_q   <= DIR_UP;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end else if (dn_go) begin
                        dir_q   <= DIR_DOWN;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    step_q  <= 1'b1;
                    timer_q <= '0;
                    state_q <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (timer_q == TW'(PULSE_W - 1)) begin
                        step_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= ST_LOW;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_LOW: begin
                    if (timer_q == TW'(GAP_W - 1)) begin
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    step_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    timer_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign step_clk = step_q;
    assign up_down  = dir_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_pulse_gen
//  Purpose  : Directed self-checking bench for step_pulse_gen (default
//             parameters). Edge numbering: edge 0 is the first rising clk
//             edge after an input change; a clean press shows step_clk high
//             from edge 20.
//  Revision : 1.0  initial release
// ============================================================================
module tb_step_pulse_gen;
    import step_gen_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic step_clk;
    logic up_down;
    logic busy;

    int checks = 0;
    int failures = 0;

    step_pulse_gen dut (
        .clk      (clk),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .step_clk (step_clk),
        .up_down  (up_down),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Advance n edges, sampling 1 time unit after each, and summarise outputs
    task automatic run(input int n, input logic dir, output int pulses,
                       output int first_rise, output int high_cnt,
                       output int busy_cnt, output int ud_bad);
        logic prev_s;
        logic prev_ud;
        prev_s = step_clk;
        prev_ud = up_down;
        pulses = 0; first_rise = -1; high_cnt = 0; busy_cnt = 0; ud_bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (step_clk && !prev_s) begin
                pulses++;
                if (first_rise < 0) first_rise = i;
                if (prev_ud !== dir) ud_bad++;
            end
            if (step_clk) begin
                high_cnt++;
                if (up_down !== dir) ud_bad++;
            end
            if (busy) busy_cnt++;
            prev_s = step_clk;
            prev_ud = up_down;
        end
    endtask

    task automatic test_reset();
        int p, fr, hc, bc, ub;
        reset = 1'b0;
        run(5, DIR_UP, p, fr, hc, bc, ub);
        checks++; if (step_clk !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", step_clk); end
        checks++; if (up_down !== 1'b0) begin failures++; $display("FAIL reset_updown got=%b exp=0", up_down); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b1;
        run(5, DIR_UP, p, fr, hc, bc, ub);
    endtask

`ifndef AUTO_REPEAT_EN
    task automatic test_clean_up();
        int p, fr, hc, bc, ub;
        btn_up = 1'b1;
        run(100, DIR_UP, p, fr, hc, bc, ub);
        checks++; if (p !== 1) begin failures++; $display("FAIL clean_pulses got=%0d exp=1", p); end
        checks++; if (fr !== 20) begin failures++; $display("FAIL clean_rise_edge got=%0d exp=20", fr); end
        checks++; if (hc !== 4) begin failures++; $display("FAIL clean_high_len got=%0d exp=4", hc); end
        checks++; if (bc !== 9) begin failures++; $display("FAIL clean_busy_len got=%0d exp=9", bc); end
        checks++; if (ub !== 0) begin failures++; $display("FAIL clean_dir got=%0d bad samples exp=0", ub); end
        btn_up = 1'b0;
        run(60, DIR_UP, p, fr, hc, bc, ub);
        checks++; if (p !== 0) begin failures++; $display("FAIL release_pulses got=%0d exp=0", p); end
    endtask

    task automatic test_bounce_down();
        int p, fr, hc, bc, ub;
        int tp = 0;
        int tub = 0;
        for (int k = 0; k < 10; k++) begin
            btn_down = (k % 2 == 0);
            run(3, DIR_DOWN, p, fr, hc, bc, ub);
            tp += p; tub += ub;
        end
        btn_down = 1'b1;
        run(80, DIR_DOWN, p, fr, hc, bc, ub);
        tp += p; tub += ub;
        checks++; if (tp !== 1) begin failures++; $display("FAIL bounce_pulses got=%0d exp=1", tp); end
        checks++; if (tub !== 0) begin failures++; $display("FAIL bounce_dir got=%0d bad samples exp=0", tub); end
        btn_down = 1'b0;
        run(40, DIR_DOWN, p, fr, hc, bc, ub);
        checks++; if (up_down !== 1'b1) begin failures++; $display("FAIL bounce_dir_hold got=%b exp=1", up_down); end
    endtask

    task automatic test_glitch();
        int p, fr, hc, bc, ub;
        int tp = 0;
        int tb = 0;
        btn_up = 1'b1;
        run(10, DIR_UP, p, fr, hc, bc, ub);
        tp += p; tb += bc;
        btn_up = 1'b0;
        run(40, DIR_UP, p, fr, hc, bc, ub);
        tp += p; tb += bc;
        checks++; if (tp !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", tp); end
        checks++; if (tb !== 0) begin failures++; $display("FAIL glitch_busy got=%0d cycles exp=0", tb); end
    endtask

    task automatic test_both();
        int p, fr, hc, bc, ub;
        btn_up = 1'b1; btn_down = 1'b1;
        run(50, DIR_UP, p, fr, hc, bc, ub);
        checks++; if (p !== 0) begin failures++; $display("FAIL both_pulses got=%0d exp=0", p); end
        btn_up = 1'b0; btn_down = 1'b0;
        run(40, DIR_UP, p, fr, hc, bc, ub);
        btn_up = 1'b1;
        run(60, DIR_UP, p, fr, hc, bc, ub);
        checks++; if (p !== 1) begin failures++; $display("FAIL lone_up_pulses got=%0d exp=1", p); end
        checks++; if (fr !== 20) begin failures++; $display("FAIL lone_up_rise got=%0d exp=20", fr); end
        checks++; if (ub !== 0) begin failures++; $display("FAIL lone_up_dir got=%0d bad samples exp=0", ub); end
        btn_up = 1'b0;
        run(40, DIR_UP, p, fr, hc, bc, ub);
    endtask
`endif

    task automatic test_reset_mid_pulse();
        int p, fr, hc, bc, ub;
        btn_up = 1'b1;
        run(23, DIR_UP, p, fr, hc, bc, ub);
        checks++; if (step_clk !== 1'b1) begin failures++; $display("FAIL mid_pulse_high got=%b exp=1", step_clk); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (step_clk !== 1'b0) begin failures++; $display("FAIL async_reset_step got=%b exp=0", step_clk); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
        btn_up = 1'b0;
        run(3, DIR_UP, p, fr, hc, bc, ub);
        reset = 1'b1;
        run(80, DIR_UP, p, fr, hc, bc, ub);
        checks++; if (p !== 0) begin failures++; $display("FAIL post_reset_pulses got=%0d exp=0", p); end
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int rises[$];
        logic prev_s;
        prev_s = step_clk;
        btn_up = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i == 300) btn_up = 1'b0;
            @(posedge clk);
            #1;
            if (step_clk && !prev_s) rises.push_back(i);
            prev_s = step_clk;
        end
        checks++; if (rises.size() !== 8) begin failures++; $display("FAIL repeat_count got=%0d exp=8", rises.size()); end
        if (rises.size() >= 2) begin
            checks++; if (rises[0] !== 20) begin failures++; $display("FAIL repeat_first got=%0d exp=20", rises[0]); end
            checks++; if (rises[1] !== 115) begin failures++; $display("FAIL repeat_second got=%0d exp=115", rises[1]); end
            for (int k = 2; k < rises.size(); k++) begin
                checks++;
                if (rises[k] - rises[k-1] !== 32) begin
                    failures++;
                    $display("FAIL repeat_spacing idx=%0d got=%0d exp=32", k, rises[k] - rises[k-1]);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`else
        test_clean_up();
        test_bounce_down();
        test_glitch();
        test_both();
`endif
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
